floor_switch: RTL
=================

# floor_switch

Floor-transition controller for the tower map. It owns the current floor index and the player's tile position. It drives the floor index into the stair-position lookup and consumes that lookup's stair coordinates to place the player on arrival. On a stair event it fades the display out, steps the floor, handshakes a map reload, places the player on the matching stair of the new floor, and fades back in.

## Interface
- MAX_FLOOR, 1: highest valid floor index; the lowest is 0.
- FADE_CYCLES, 16: clock cycles per fade brightness step; must be ≥1.
- START_X, 1: player column after reset.
- START_Y, 11: player row after reset.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- stair_up  in  1  single-cycle pulse: the player stepped onto the up stair.
- stair_down  in  1  single-cycle pulse: the player stepped onto the down stair.
- move_valid  in  1  qualifies move_x/move_y.
- move_x, move_y  in  4 each  new player tile from the movement logic.
- pos_down_x, pos_down_y, pos_up_x, pos_up_y  in  4 each  stair coordinates from the lookup for the current `floor`; combinational.
- floor  out  16  current floor index, registered; feeds the lookup.
- player_x, player_y  out  4 each  player tile, registered.
- load_req  out  1  map reload request, registered.
- load_ack  in  1  map loader completion.
- fade  out  3  display brightness, 7 = full and 0 = black, registered.
- busy  out  1  high whenever the state is not IDLE, registered.

## Operation
States: IDLE, FADE_OUT, SWITCH, LOAD, PLACE, FADE_IN.

- **Reset (any time, including mid-transition):**
  - state = IDLE, floor = 0, player = (START_X, START_Y).
  - fade = 7, load_req = 0, busy = 0, fade counter = 0.
- **IDLE:**
  - move_valid loads move_x/move_y into player_x/player_y.
  - stair_up with floor < MAX_FLOOR → dir = up, go to FADE_OUT.
  - stair_down with floor > 0 → dir = down, go to FADE_OUT.
  - stair_up and stair_down high in the same cycle: both ignored, no transition.
  - Out-of-range requests (up at MAX_FLOOR, down at 0) are ignored.
  - A move in the same cycle as an accepted stair event is still applied; PLACE later overwrites it.
- **FADE_OUT:**
  - A counter runs 0..FADE_CYCLES-1.
  - At terminal count: if fade == 0, go to SWITCH; otherwise fade decrements by 1.
- **SWITCH (1 cycle):** floor ← floor+1 (dir up) or floor−1 (dir down), then go to LOAD.
- **LOAD:**
  - load_req = 1 for every cycle in LOAD.
  - When load_ack is sampled high, go to PLACE; load_req is 0 from the next cycle.
  - load_ack is ignored outside LOAD.
- **PLACE (1 cycle):**
  - dir up → player ← (pos_down_x, pos_down_y), i.e. the new floor's down stair.
  - dir down → player ← (pos_up_x, pos_up_y), i.e. the new floor's up stair.
  - Go to FADE_IN.
- **FADE_IN:** at terminal count, if fade == 7 go to IDLE; otherwise fade increments by 1.
- **While busy:** stair_up, stair_down and move_valid are ignored. Nothing is queued.
- **Width rules:**
  - floor arithmetic is 16-bit unsigned and can never wrap, given the range checks.
  - fade never leaves 0..7.

## Timing
- Accepting a stair pulse makes busy = 1 on the next cycle.
- FADE_OUT lasts 8·FADE_CYCLES cycles (fade 7→0, plus one full period at 0).
- SWITCH lasts 1 cycle.
- LOAD lasts N ≥ 1 cycles, where N is the cycle in which load_ack is first high.
- PLACE lasts 1 cycle.
- FADE_IN lasts 8·FADE_CYCLES cycles.
- Total busy duration = 16·FADE_CYCLES + 2 + N cycles.
- floor changes in the cycle after SWITCH. The lookup outputs are stable from that cycle, so PLACE always samples the new floor's coordinates.
- load_req rises on the first LOAD cycle and falls the cycle after load_ack is sampled.
- player changes only on IDLE moves, on PLACE, and on reset.

## Test plan
All scenarios use FADE_CYCLES = 2.

1. **Reset values:** assert rst mid-simulation → floor = 0, player = (1, 11), fade = 7, busy = 0, load_req = 0, all immediately, without waiting for a clock edge.
2. **Up with immediate ack:**
   - Stimulus: floor 0; lookup gives floor-1 down stair (2, 1); stair_up pulse; load_ack tied high.
   - Required: fade steps 7→0 every 2 cycles; floor = 1; player = (2, 1); fade back to 7; busy high for 35 cycles.
3. **Down:**
   - Stimulus: from floor 1; lookup gives floor-0 up stair (2, 11); stair_down pulse.
   - Required: floor = 0, player = (2, 11), busy returns to 0.
4. **Ignored requests:**
   - stair_down at floor 0, stair_up at floor MAX_FLOOR, and simultaneous up+down → no state change, busy stays 0.
   - stair_up or move_valid during FADE_IN → no effect on floor or player.
5. **Held handshake:** load_ack arrives 5 cycles into LOAD → load_req high for exactly 5 cycles, fade held at 0, PLACE follows on the next cycle.
6. **Reset mid-transition:** rst during FADE_OUT at fade = 3 → IDLE, floor = 0, fade = 7, load_req = 0; a subsequent stair_up is accepted normally.

Source files
------------

// File: rtl/floor_switch.sv
// ---------------------------------------------------------------------------
// floor_switch
//   Floor-transition controller for the tower map. Owns the current floor
//   index and the player's tile position. On an accepted stair event it fades
//   the display out, steps the floor, handshakes a map reload, places the
//   player on the matching stair of the new floor, then fades back in.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   stair_up, stair_down     single-cycle stair pulses from the movement logic
//   move_valid, move_x/_y    player tile update, honoured only while idle
//   pos_down_*/pos_up_*      stair coordinates for the current floor (comb.)
//   floor                    current floor index, drives the stair lookup
//   player_x, player_y       player tile
//   load_req / load_ack      map reload handshake
//   fade                     display brightness, 7 = full, 0 = black
//   busy                     high while a transition is in progress
// ---------------------------------------------------------------------------
module floor_switch #(
  parameter int MAX_FLOOR   = 1,
  parameter int FADE_CYCLES = 16,
  parameter int START_X     = 1,
  parameter int START_Y     = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stair_up,
  input  logic        stair_down,
  input  logic        move_valid,
  input  logic [3:0]  move_x,
  input  logic [3:0]  move_y,
  input  logic [3:0]  pos_down_x,
  input  logic [3:0]  pos_down_y,
  input  logic [3:0]  pos_up_x,
  input  logic [3:0]  pos_up_y,
  output logic [15:0] floor,
  output logic [3:0]  player_x,
  output logic [3:0]  player_y,
  output logic        load_req,
  input  logic        load_ack,
  output logic [2:0]  fade,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_FADE_OUT, S_SWITCH, S_LOAD, S_PLACE, S_FADE_IN
  } state_t;

  localparam int              CW        = (FADE_CYCLES > 1) ? $clog2(FADE_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST  = CW'(FADE_CYCLES - 1);
  localparam logic [15:0]     FLOOR_TOP = 16'(MAX_FLOOR);

  state_t        state_q, state_d;
  logic          dir_up_q, dir_up_d;
  logic [15:0]   floor_q, floor_d;
  logic [3:0]    px_q, px_d;
  logic [3:0]    py_q, py_d;
  logic [2:0]    fade_q, fade_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load_req_q, load_req_d;
  logic          busy_q, busy_d;

  logic req_up, req_dn, cnt_done;

  // Simultaneous up+down cancels; out-of-range steps are dropped here so the
  // floor arithmetic below can never wrap.
  assign req_up   = stair_up & ~stair_down & (floor_q < FLOOR_TOP);
  assign req_dn   = stair_down & ~stair_up & (floor_q != 16'd0);
  assign cnt_done = (cnt_q == CNT_LAST);

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dir_up_q   <= 1'b0;
      floor_q    <= 16'd0;
      px_q       <= 4'(START_X);
      py_q       <= 4'(START_Y);
      fade_q     <= 3'd7;
      cnt_q      <= '0;
      load_req_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_up_q   <= dir_up_d;
      floor_q    <= floor_d;
      px_q       <= px_d;
      py_q       <= py_d;
      fade_q     <= fade_d;
      cnt_q      <= cnt_d;
      load_req_q <= load_req_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (req_up || req_dn) state_d = S_FADE_OUT;
      // The last period at fade 0 is spent fully black before switching.
      S_FADE_OUT: if (cnt_done && fade_q == 3'd0) state_d = S_SWITCH;
      S_SWITCH:   state_d = S_LOAD;
      S_LOAD:     if (load_ack) state_d = S_PLACE;
      S_PLACE:    state_d = S_FADE_IN;
      S_FADE_IN:  if (cnt_done && fade_q == 3'd7) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Datapath / registered-output next values
  always_comb begin
    dir_up_d   = dir_up_q;
    floor_d    = floor_q;
    px_d       = px_q;
    py_d       = py_q;
    fade_d     = fade_q;
    cnt_d      = '0;
    busy_d     = (state_d != S_IDLE);
    load_req_d = (state_d == S_LOAD);
    case (state_q)
      S_IDLE: begin
        if (move_valid) begin
          px_d = move_x;
          py_d = move_y;
        end
        if (req_up)      dir_up_d = 1'b1;
        else if (req_dn) dir_up_d = 1'b0;
      end
      S_FADE_OUT: begin
        cnt_d = cnt_done ? '0 : cnt_q + 1'b1;
        if (cnt_done && fade_q != 3'd0) fade_d = fade_q - 3'd1;
      end
      S_SWITCH: begin
        floor_d = dir_up_q ? floor_q + 16'd1 : floor_q - 16'd1;
      end
      S_PLACE: begin
        // Arriving from below lands on the new floor's down stair, and
        // vice versa. The lookup already reflects the new floor here.
        px_d = dir_up_q ? pos_down_x : pos_up_x;
        py_d = dir_up_q ? pos_down_y : pos_up_y;
      end
      S_FADE_IN: begin
        cnt_d = cnt_done ? '0 : cnt_q + 1'b1;
        if (cnt_done && fade_q != 3'd7) fade_d = fade_q + 3'd1;
      end
      default: ;
    endcase
  end

  assign floor    = floor_q;
  assign player_x = px_q;
  assign player_y = py_q;
  assign fade     = fade_q;
  assign load_req = load_req_q;
  assign busy     = busy_q;

endmodule
